// File: rtl/datapath_core.sv
// ---------------------------------------------------------------------------
// datapath_core
//
// Single-bus 32-bit Mini-SRC datapath. It holds the register file R0-R15,
// PC, IR, MAR, MDR, Y, the 64-bit Z register, HI/LO, the ALU, the
// select-and-encode logic, the CON flip-flop, the I/O port registers and a
// word-addressed RAM. There is no control unit in here. Every load enable
// and bus-drive strobe comes from an external controller, cycle by cycle.
//
// Configuration macro:
//   DATAPATH_MULDIV_EN  defined   -> signed mul / div opcodes are built
//                       undefined -> mul / div write Z = 0, and no
//                                    multiplier or divider is built
//
// Ports:
//   Clock              system clock, all state updates on the rising edge
//   clr                synchronous active-high clear of all registers
//                      (the RAM is not cleared)
//   Mdatain            RAM[MAR] read data, combinational
//   MDR_data_out       current MDR contents
//   IR_data_out        current IR contents, for the controller to decode
//   out_port_data      current out-port register contents
//   *_out, R_out, BA_out, in_port_out, C_out
//                      bus-drive strobes, resolved by fixed priority
//   *_enable, R_in     register load enables
//   Gra/Grb/Grc        choose the IR field ra/rb/rc as the register index
//   IncPC              with PC_enable: PC <= PC + 1 instead of the bus
//   Read               MDR input select: 1 = RAM data, 0 = bus
//   opcode             ALU operation
//   con_in             load the CON flip-flop from the bus condition
//   out_port_enable    load the out-port register from the bus
//   in_port_enable     load the in-port register with {31'b0, InPort}
//   InPort             external input bit
//   RAM_write_enable   RAM[MAR] <= MDR on the rising edge
// ---------------------------------------------------------------------------
module datapath_core #(
  parameter int MEM_DEPTH = 512
) (
  input  logic        Clock,
  input  logic        clr,
  output logic [31:0] Mdatain,
  output logic [31:0] MDR_data_out,
  output logic [31:0] IR_data_out,
  output logic [31:0] out_port_data,
  input  logic        PC_out,
  input  logic        ZHigh_out,
  input  logic        ZLow_out,
  input  logic        HI_out,
  input  logic        LO_out,
  input  logic        C_out,
  input  logic        MDR_out,
  input  logic        in_port_out,
  input  logic        R_out,
  input  logic        BA_out,
  input  logic        MDR_enable,
  input  logic        MAR_enable,
  input  logic        Z_enable,
  input  logic        Y_enable,
  input  logic        PC_enable,
  input  logic        LO_enable,
  input  logic        HI_enable,
  input  logic        IR_enable,
  input  logic        R_in,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        IncPC,
  input  logic        Read,
  input  logic [4:0]  opcode,
  input  logic        con_in,
  input  logic        out_port_enable,
  input  logic        in_port_enable,
  input  logic        InPort,
  input  logic        RAM_write_enable
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [31:0] regFile_q [16];
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [AW-1:0] mar_q;
  logic [31:0] mdr_q;
  logic [31:0] y_q;
  logic [63:0] z_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        con_q;
  logic [31:0] inPort_q;
  logic [31:0] outPort_q;

  logic [31:0] ram [MEM_DEPTH];

  logic [31:0] pc_d;
  logic [31:0] mdr_d;
  logic [63:0] z_d;
  logic        con_d;
  logic [31:0] inPort_d;

  logic [3:0]  regIndex;
  logic [31:0] cSignExt;
  logic [31:0] busValue;
  logic [4:0]  shAmt;
  logic [5:0]  shBack;
  logic [31:0] rorValue;
  logic [31:0] rolValue;

  // The register index is the OR of whichever IR fields are gated in, so
  // the controller can assert more than one select without extra decoding.
  assign regIndex = ({4{Gra}} & ir_q[26:23])
                  | ({4{Grb}} & ir_q[22:19])
                  | ({4{Grc}} & ir_q[18:15]);

  assign cSignExt = {{13{ir_q[18]}}, ir_q[18:0]};

  // Bus source mux. The controller should assert one strobe at a time. If
  // it asserts several, the fixed priority order below resolves them. With
  // BA_out, R0 reads as zero so that it can act as a "no base" register.
  always_comb begin
    busValue = '0;
    if (R_out || BA_out) begin
      if (BA_out && (regIndex == 4'd0)) begin
        busValue = '0;
      end else begin
        busValue = regFile_q[regIndex];
      end
    end else if (PC_out) begin
      busValue = pc_q;
    end else if (ZHigh_out) begin
      busValue = z_q[63:32];
    end else if (ZLow_out) begin
      busValue = z_q[31:0];
    end else if (HI_out) begin
      busValue = hi_q;
    end else if (LO_out) begin
      busValue = lo_q;
    end else if (MDR_out) begin
      busValue = mdr_q;
    end else if (in_port_out) begin
      busValue = inPort_q;
    end else if (C_out) begin
      busValue = cSignExt;
    end
  end

  // Rotates are built as two opposing shifts. When the amount is zero, the
  // back-shift distance is 32, which shifts a 32-bit value out to zero and
  // leaves the operand unchanged.
  assign shAmt    = busValue[4:0];
  assign shBack   = 6'd32 - {1'b0, shAmt};
  assign rorValue = (y_q >> shAmt) | (y_q << shBack);
  assign rolValue = (y_q << shAmt) | (y_q >> shBack);

`ifdef DATAPATH_MULDIV_EN
  logic [63:0] mulProduct;
  logic [31:0] divQuot;
  logic [31:0] divRem;

  // The operands are sign-extended to 64 bits. The low 64 bits of the
  // unsigned product of those are then the signed product.
  assign mulProduct = {{32{y_q[31]}}, y_q} * {{32{busValue[31]}}, busValue};

  // Signed divide. The quotient truncates toward zero and the remainder
  // takes the sign of the dividend. A zero divisor yields zero for both.
  always_comb begin
    divQuot = '0;
    divRem  = '0;
    if (busValue != 32'd0) begin
      divQuot = $unsigned($signed(y_q) / $signed(busValue));
      divRem  = $unsigned($signed(y_q) % $signed(busValue));
    end
  end
`endif

  // The ALU takes A from Y and B from the bus. Unlisted opcodes produce
  // B + 1, which gives the controller a PC-increment path through Z.
  always_comb begin
    z_d = {32'd0, busValue + 32'd1};
    case (opcode)
      OP_ADD, OP_ADDI: z_d = {32'd0, y_q + busValue};
      OP_SUB:          z_d = {32'd0, y_q - busValue};
      OP_AND, OP_ANDI: z_d = {32'd0, y_q & busValue};
      OP_OR, OP_ORI:   z_d = {32'd0, y_q | busValue};
      OP_ROR:          z_d = {32'd0, rorValue};
      OP_ROL:          z_d = {32'd0, rolValue};
      OP_SHR:          z_d = {32'd0, y_q >> shAmt};
      OP_SHRA:         z_d = {32'd0, $unsigned($signed(y_q) >>> shAmt)};
      OP_SHL:          z_d = {32'd0, y_q << shAmt};
`ifdef DATAPATH_MULDIV_EN
      OP_DIV:          z_d = {divRem, divQuot};
      OP_MUL:          z_d = mulProduct;
`else
      OP_DIV, OP_MUL:  z_d = '0;
`endif
      OP_NEG:          z_d = {32'd0, 32'd0 - busValue};
      OP_NOT:          z_d = {32'd0, ~busValue};
      default:         z_d = {32'd0, busValue + 32'd1};
    endcase
  end

  // The branch condition is evaluated on the bus value. The C2 field of
  // IR selects which test applies.
  always_comb begin
    con_d = 1'b0;
    case (ir_q[20:19])
      2'b00: con_d = (busValue == 32'd0);
      2'b01: con_d = (busValue != 32'd0);
      2'b10: con_d = ~busValue[31];
      2'b11: con_d = busValue[31];
      default: con_d = 1'b0;
    endcase
  end

  // Next-state values for the registers whose input is more than just the bus.
  assign pc_d     = IncPC ? (pc_q + 32'd1) : busValue;
  assign mdr_d    = Read ? Mdatain : busValue;
  assign inPort_d = {31'd0, InPort};

  // Architectural register state. clr wins over every enable in the same
  // cycle. MAR keeps only the bits that address the RAM, because nothing
  // ever reads MAR back onto the bus.
  always_ff @(posedge Clock) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        regFile_q[i] <= '0;
      end
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      z_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      con_q     <= 1'b0;
      inPort_q  <= '0;
      outPort_q <= '0;
    end else begin
      if (R_in) begin
        regFile_q[regIndex] <= busValue;
      end
      if (PC_enable) begin
        pc_q <= pc_d;
      end
      if (IR_enable) begin
        ir_q <= busValue;
      end
      if (MAR_enable) begin
        mar_q <= busValue[AW-1:0];
      end
      if (MDR_enable) begin
        mdr_q <= mdr_d;
      end
      if (Y_enable) begin
        y_q <= busValue;
      end
      if (Z_enable) begin
        z_q <= z_d;
      end
      if (HI_enable) begin
        hi_q <= busValue;
      end
      if (LO_enable) begin
        lo_q <= busValue;
      end
      if (con_in) begin
        con_q <= con_d;
      end
      if (in_port_enable) begin
        inPort_q <= inPort_d;
      end
      if (out_port_enable) begin
        outPort_q <= busValue;
      end
    end
  end

  // RAM write port. Writes are synchronous and the read is combinational.
  // A read of the address being written therefore returns the old word
  // until the edge has passed.
  always_ff @(posedge Clock) begin
    if (RAM_write_enable) begin
      ram[mar_q] <= mdr_q;
    end
  end

  assign Mdatain       = ram[mar_q];
  assign MDR_data_out  = mdr_q;
  assign IR_data_out   = ir_q;
  assign out_port_data = outPort_q;

endmodule

// File: tb/tb_datapath_core.sv
// ---------------------------------------------------------------------------
// tb_datapath_core
//
// Acts as the external controller for datapath_core. Constants enter the
// datapath only through its own paths: a 1 from the in-port, then shift/or
// steps in the ALU. Results are read back by routing them through the bus
// into MDR. Expected values come from a behavioural ALU/CON model.
// ---------------------------------------------------------------------------
module tb_datapath_core;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_SHL = 5'b01011;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_MUL = 5'b10000;

  logic        Clock = 1'b0;
  logic        clr;
  logic [31:0] Mdatain, MDR_data_out, IR_data_out, out_port_data;
  logic PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out;
  logic R_out, BA_out;
  logic MDR_enable, MAR_enable, Z_enable, Y_enable, PC_enable, LO_enable, HI_enable;
  logic IR_enable, R_in, Gra, Grb, Grc, IncPC, Read;
  logic [4:0] opcode;
  logic con_in, out_port_enable, in_port_enable, InPort, RAM_write_enable;

  int assertCount = 0;
  int failCount = 0;

  datapath_core dut (
    .Clock(Clock), .clr(clr), .Mdatain(Mdatain), .MDR_data_out(MDR_data_out),
    .IR_data_out(IR_data_out), .out_port_data(out_port_data),
    .PC_out(PC_out), .ZHigh_out(ZHigh_out), .ZLow_out(ZLow_out), .HI_out(HI_out),
    .LO_out(LO_out), .C_out(C_out), .MDR_out(MDR_out), .in_port_out(in_port_out),
    .R_out(R_out), .BA_out(BA_out), .MDR_enable(MDR_enable), .MAR_enable(MAR_enable),
    .Z_enable(Z_enable), .Y_enable(Y_enable), .PC_enable(PC_enable),
    .LO_enable(LO_enable), .HI_enable(HI_enable), .IR_enable(IR_enable), .R_in(R_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .opcode(opcode),
    .con_in(con_in), .out_port_enable(out_port_enable), .in_port_enable(in_port_enable),
    .InPort(InPort), .RAM_write_enable(RAM_write_enable)
  );

  // Free-running clock
  always #5 Clock = ~Clock;

  // Safety net in case a cycle loop ever runs away
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drop every strobe and enable back to idle
  task automatic clearCtrl();
    clr = 0; PC_out = 0; ZHigh_out = 0; ZLow_out = 0; HI_out = 0; LO_out = 0;
    C_out = 0; MDR_out = 0; in_port_out = 0; R_out = 0; BA_out = 0;
    MDR_enable = 0; MAR_enable = 0; Z_enable = 0; Y_enable = 0; PC_enable = 0;
    LO_enable = 0; HI_enable = 0; IR_enable = 0; R_in = 0; Gra = 0; Grb = 0;
    Grc = 0; IncPC = 0; Read = 0; opcode = 5'd0; con_in = 0;
    out_port_enable = 0; in_port_enable = 0; InPort = 0; RAM_write_enable = 0;
  endtask

  // Run one controller step: the currently driven controls take effect at
  // the next rising edge. Outputs are then stable and ready to sample.
  task automatic applyStimulus();
    @(posedge Clock);
    #1;
    clearCtrl();
  endtask

  // Count one comparison and report it if it mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference ALU, written from the operation definitions
  function automatic logic [63:0] aluModel(input logic [4:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    int unsigned n;
    logic [31:0] r;
    int sa, sb;
    longint pa, pb;
    n = b[4:0];
    r = a;
    case (op)
      5'd3, 5'd12: return {32'd0, a + b};
      5'd4:        return {32'd0, a - b};
      5'd5, 5'd13: return {32'd0, a & b};
      5'd6, 5'd14: return {32'd0, a | b};
      5'd7: begin repeat (n) r = {r[0], r[31:1]}; return {32'd0, r}; end
      5'd8: begin repeat (n) r = {r[30:0], r[31]}; return {32'd0, r}; end
      5'd9: begin repeat (n) r = {1'b0, r[31:1]}; return {32'd0, r}; end
      5'd10: begin repeat (n) r = {r[31], r[31:1]}; return {32'd0, r}; end
      5'd11: begin repeat (n) r = {r[30:0], 1'b0}; return {32'd0, r}; end
      5'd15: begin
`ifdef DATAPATH_MULDIV_EN
        if (b == 32'd0) return 64'd0;
        sa = a; sb = b;
        return {32'(sa % sb), 32'(sa / sb)};
`else
        return 64'd0;
`endif
      end
      5'd16: begin
`ifdef DATAPATH_MULDIV_EN
        sa = a; sb = b; pa = sa; pb = sb;
        return 64'(pa * pb);
`else
        return 64'd0;
`endif
      end
      5'd17: return {32'd0, 32'd0 - b};
      5'd18: return {32'd0, ~b};
      default: return {32'd0, b + 32'd1};
    endcase
  endfunction

  function automatic logic conModel(input logic [1:0] c2, input logic [31:0] v);
    case (c2)
      2'd0: return v == 32'd0;
      2'd1: return v != 32'd0;
      2'd2: return $signed(v) >= 0;
      default: return $signed(v) < 0;
    endcase
  endfunction

  // Assemble v in Z[31:0] from a 1 on the in-port with shift-left/or steps.
  // This clobbers Y, Z and the in-port register.
  task automatic buildConst(input logic [31:0] v);
    bit started;
    started = 0;
    InPort = 1; in_port_enable = 1; applyStimulus();
    Y_enable = 1; applyStimulus();
    Z_enable = 1; opcode = OP_ADD; applyStimulus();
    for (int i = 31; i >= 0; i--) begin
      if (started) begin
        ZLow_out = 1; Y_enable = 1; applyStimulus();
        in_port_out = 1; Z_enable = 1; opcode = OP_SHL; applyStimulus();
      end
      if (v[i]) begin
        ZLow_out = 1; Y_enable = 1; applyStimulus();
        in_port_out = 1; Z_enable = 1; opcode = OP_OR; applyStimulus();
        started = 1;
      end
    end
  endtask

  task automatic writeRam(input logic [31:0] addr, input logic [31:0] data);
    buildConst(addr); ZLow_out = 1; MAR_enable = 1; applyStimulus();
    buildConst(data); ZLow_out = 1; MDR_enable = 1; applyStimulus();
    RAM_write_enable = 1; applyStimulus();
  endtask

  // Put a on Y and b on the bus (via HI), then read Z back through MDR
  task automatic aluCheck(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    logic [31:0] lo, hi;
    buildConst(b); ZLow_out = 1; HI_enable = 1; applyStimulus();
    buildConst(a); ZLow_out = 1; Y_enable = 1; applyStimulus();
    HI_out = 1; Z_enable = 1; opcode = op; applyStimulus();
    ZLow_out = 1; MDR_enable = 1; applyStimulus(); lo = MDR_data_out;
    ZHigh_out = 1; MDR_enable = 1; applyStimulus(); hi = MDR_data_out;
    checkOutput($sformatf("alu op%0d a=%h b=%h", op, a, b), {hi, lo}, aluModel(op, a, b));
  endtask

  task automatic conCheck(input logic [1:0] c2, input logic [31:0] v);
    buildConst({11'd0, c2, 19'd0}); ZLow_out = 1; IR_enable = 1; applyStimulus();
    buildConst(v); ZLow_out = 1; con_in = 1; applyStimulus();
    checkOutput($sformatf("con c2=%0d v=%h", c2, v), {63'd0, dut.con_q}, {63'd0, conModel(c2, v)});
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;

    clearCtrl();
    clr = 1; applyStimulus();
    clr = 1; applyStimulus();

    // Reset: load arbitrary values, then clear with enables still asserted
    InPort = 1; in_port_enable = 1; applyStimulus();
    in_port_out = 1; PC_enable = 1; MDR_enable = 1; MAR_enable = 1; Y_enable = 1;
    HI_enable = 1; LO_enable = 1; IR_enable = 1; R_in = 1; Gra = 1; Z_enable = 1;
    opcode = 5'b11111; out_port_enable = 1; applyStimulus();
    clr = 1; in_port_out = 1; PC_enable = 1; MDR_enable = 1; Z_enable = 1;
    IR_enable = 1; R_in = 1; applyStimulus();
    checkOutput("reset MDR_data_out", MDR_data_out, 64'd0);
    checkOutput("reset MAR", dut.mar_q, 64'd0);
    checkOutput("reset IR", IR_data_out, 64'd0);
    checkOutput("reset out-port", out_port_data, 64'd0);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("reset R%0d", i), dut.regFile_q[i], 64'd0);
    PC_out = 1; MDR_enable = 1; applyStimulus();
    checkOutput("reset PC", MDR_data_out, 64'd0);
    ZLow_out = 1; MDR_enable = 1; applyStimulus();
    checkOutput("reset ZLow", MDR_data_out, 64'd0);
    HI_out = 1; MDR_enable = 1; applyStimulus();
    checkOutput("reset HI", MDR_data_out, 64'd0);
    in_port_out = 1; MDR_enable = 1; applyStimulus();
    checkOutput("reset in-port", MDR_data_out, 64'd0);

    // ld R2, 0x95(R0)
    writeRam(32'h95, 32'h1234ABCD);
    writeRam(32'h0, 32'h01000095);
    PC_enable = 1; applyStimulus();
    PC_out = 1; MAR_enable = 1; applyStimulus();
    checkOutput("ld T0 Mdatain", Mdatain, 64'h01000095);
    Read = 1; MDR_enable = 1; applyStimulus();
    MDR_out = 1; IR_enable = 1; applyStimulus();
    checkOutput("ld T2 IR", IR_data_out, 64'h01000095);
    Grb = 1; BA_out = 1; Y_enable = 1; applyStimulus();
    C_out = 1; Z_enable = 1; opcode = OP_ADD; applyStimulus();
    ZLow_out = 1; MAR_enable = 1; applyStimulus();
    Read = 1; MDR_enable = 1; applyStimulus();
    MDR_out = 1; Gra = 1; R_in = 1; applyStimulus();
    checkOutput("ld MAR", dut.mar_q, 64'h95);
    checkOutput("ld MDR_data_out", MDR_data_out, 64'h1234ABCD);
    MDR_enable = 1; applyStimulus();
    Gra = 1; R_out = 1; MDR_enable = 1; applyStimulus();
    checkOutput("ld R2", MDR_data_out, 64'h1234ABCD);

    // PC increment and bus priority (PC over ZLow)
    PC_enable = 1; IncPC = 1; applyStimulus();
    PC_enable = 1; IncPC = 1; applyStimulus();
    PC_out = 1; ZLow_out = 1; MDR_enable = 1; applyStimulus();
    checkOutput("incpc and priority", MDR_data_out, 64'd2);

    // BA_out with index 0 reads zero, R_out reads R0 itself
    buildConst(32'd5); ZLow_out = 1; Grb = 1; R_in = 1; applyStimulus();
    Grb = 1; BA_out = 1; MDR_enable = 1; applyStimulus();
    checkOutput("BA_out R0", MDR_data_out, 64'd0);
    Grb = 1; R_out = 1; MDR_enable = 1; applyStimulus();
    checkOutput("R_out R0", MDR_data_out, 64'd5);
    Gra = 1; BA_out = 1; MDR_enable = 1; applyStimulus();
    checkOutput("BA_out R2", MDR_data_out, 64'h1234ABCD);

    // C_out sign extension and the out-port
    buildConst(32'h0007FFFF); ZLow_out = 1; IR_enable = 1; out_port_enable = 1; applyStimulus();
    checkOutput("out-port", out_port_data, 64'h0007FFFF);
    C_out = 1; MDR_enable = 1; applyStimulus();
    checkOutput("C_out negative", MDR_data_out, 64'hFFFFFFFF);
    buildConst(32'h0003FFFF); ZLow_out = 1; IR_enable = 1; applyStimulus();
    C_out = 1; MDR_enable = 1; applyStimulus();
    checkOutput("C_out positive", MDR_data_out, 64'h0003FFFF);

    // st, then a read and write of the same address in one cycle
    writeRam(32'h20, 32'hDEADBEEF);
    checkOutput("st Mdatain", Mdatain, 64'hDEADBEEF);
    buildConst(32'hCAFE0001); ZLow_out = 1; MDR_enable = 1; applyStimulus();
    Read = 1; MDR_enable = 1; RAM_write_enable = 1; applyStimulus();
    checkOutput("rdw old data", MDR_data_out, 64'hDEADBEEF);
    checkOutput("rdw new data", Mdatain, 64'hCAFE0001);

    // CON: the listed case plus random conditions
    conCheck(2'd1, 32'd9);
    conCheck(2'd1, 32'd0);
    for (int i = 0; i < 6; i++) begin
      conCheck(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
    end

    // Directed ALU corner cases
    aluCheck(OP_ADD, 32'h7FFFFFFF, 32'd1);
    aluCheck(OP_SUB, 32'd5, 32'd7);
    aluCheck(OP_MUL, 32'hFFFFFFFA, 32'd4);
    aluCheck(OP_DIV, 32'd17, 32'd5);
    aluCheck(OP_DIV, 32'hFFFFFFEF, 32'd5);
    aluCheck(OP_DIV, 32'd17, 32'd0);
    aluCheck(5'b00111, 32'h80000001, 32'd0);
    aluCheck(5'b01000, 32'h80000001, 32'd31);
    aluCheck(5'b01010, 32'h80000000, 32'd31);

    // Random ALU operations, including the unlisted opcodes
    for (int i = 0; i < 20; i++) begin
      op = 5'($urandom_range(0, 31));
      a = $urandom;
      b = $urandom;
      if (op == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      aluCheck(op, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
